// File: rtl/mod_dma_copy.sv
// mod_dma_copy: word-copy DMA engine that drives the RAM data port.
// Each word is read (address cycle + capture cycle) and then written,
// strictly in ascending order. Every output is a register, loaded from
// the next-state decode, so nothing seen outside the block can glitch.
module mod_dma_copy #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] remaining,
  output logic             m_de,
  output logic             m_drw,
  output logic [31:0]      m_daddr,
  output logic [31:0]      m_din,
  input  logic [31:0]      m_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR,
    S_FIN
  } state_t;

  state_t state, state_next;

  logic [31:0]      sptr, sptr_next;
  logic [31:0]      dptr, dptr_next;
  logic [31:0]      data_buf, buf_next;
  logic [CNT_W-1:0] rem_next;
  logic             err_flag, err_next;

  logic             busy_d, done_d, err_d, de_d, drw_d;
  logic [31:0]      addr_d, din_d;

  // State and datapath registers; reset returns everything to an idle, zeroed engine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sptr      <= '0;
      dptr      <= '0;
      data_buf  <= '0;
      remaining <= '0;
      err_flag  <= 1'b0;
    end else begin
      state     <= state_next;
      sptr      <= sptr_next;
      dptr      <= dptr_next;
      data_buf  <= buf_next;
      remaining <= rem_next;
      err_flag  <= err_flag_next_or_hold(err_next);
    end
  end

  function automatic logic err_flag_next_or_hold(input logic e);
    return e;
  endfunction

  // Next-state and datapath updates; a WR cycle always commits, even when aborted.
  always_comb begin
    state_next = state;
    sptr_next  = sptr;
    dptr_next  = dptr;
    buf_next   = data_buf;
    rem_next   = remaining;
    err_next   = err_flag;
    case (state)
      S_IDLE: begin
        if (start) begin
          sptr_next = src;
          dptr_next = dst;
          rem_next  = count;
          err_next  = 1'b0;
          if ((src[1:0] != 2'b00) || (dst[1:0] != 2'b00)) begin
            err_next   = 1'b1;
            state_next = S_FIN;
          end else if (count == '0) begin
            state_next = S_FIN;
          end else begin
            state_next = S_RD_ADDR;
          end
        end
      end
      S_RD_ADDR: begin
        state_next = abort ? S_IDLE : S_RD_DATA;
      end
      S_RD_DATA: begin
        buf_next   = m_dout;
        state_next = abort ? S_IDLE : S_WR;
      end
      S_WR: begin
        sptr_next = sptr + 32'd4;
        dptr_next = dptr + 32'd4;
        rem_next  = remaining - CNT_W'(1);
        if (abort) begin
          state_next = S_IDLE;
        end else if (remaining == CNT_W'(1)) begin
          state_next = S_FIN;
        end else begin
          state_next = S_RD_ADDR;
        end
      end
      S_FIN: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the state being entered.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    err_d  = 1'b0;
    de_d   = 1'b0;
    drw_d  = 1'b0;
    addr_d = '0;
    din_d  = '0;
    case (state_next)
      S_RD_ADDR, S_RD_DATA: begin
        busy_d = 1'b1;
        de_d   = 1'b1;
        addr_d = sptr_next;
      end
      S_WR: begin
        busy_d = 1'b1;
        de_d   = 1'b1;
        drw_d  = 1'b1;
        addr_d = dptr_next;
        din_d  = buf_next;
      end
      S_FIN: begin
        done_d = 1'b1;
        err_d  = err_next;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Output registers; they line up exactly with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      m_de    <= 1'b0;
      m_drw   <= 1'b0;
      m_daddr <= '0;
      m_din   <= '0;
    end else begin
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
      m_de    <= de_d;
      m_drw   <= drw_d;
      m_daddr <= addr_d;
      m_din   <= din_d;
    end
  end

endmodule

// File: tb/tb_mod_dma_copy.sv
// tb_mod_dma_copy: drives mod_dma_copy against a behavioural RAM and checks
// it cycle by cycle against a word-level copy model.
module tb_mod_dma_copy;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [31:0]      src;
  logic [31:0]      dst;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] remaining;
  logic             m_de;
  logic             m_drw;
  logic [31:0]      m_daddr;
  logic [31:0]      m_din;
  logic [31:0]      m_dout;

  int testsRun  = 0;
  int failCount = 0;
  int deCount   = 0;
  int wrCount   = 0;
  int doneCount = 0;

  logic [31:0] mem    [logic [31:0]];
  logic [31:0] refMem [logic [31:0]];
  logic [31:0] ramQ = 32'h0;

  mod_dma_copy #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .src       (src),
    .dst       (dst),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .remaining (remaining),
    .m_de      (m_de),
    .m_drw     (m_drw),
    .m_daddr   (m_daddr),
    .m_din     (m_din),
    .m_dout    (m_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memRead(input logic [31:0] byteAddr);
    logic [31:0] w;
    w = byteAddr >> 2;
    return mem.exists(w) ? mem[w] : 32'h0;
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] byteAddr);
    logic [31:0] w;
    w = byteAddr >> 2;
    return refMem.exists(w) ? refMem[w] : 32'h0;
  endfunction

  // RAM with a one-cycle registered read; read data is forced to zero while disabled.
  always @(posedge clk) begin
    if (m_de) begin
      if (m_drw) mem[m_daddr >> 2] = m_din;
      else       ramQ <= memRead(m_daddr);
    end
  end

  assign m_dout = m_de ? ramQ : 32'h0;

  // Activity counters used to prove that some requests never touch memory.
  always @(posedge clk) begin
    if (m_de)          deCount++;
    if (m_de && m_drw) wrCount++;
  end

  // Completion pulses are counted away from the active edge.
  always @(negedge clk) begin
    if (rst_n && done) doneCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    testsRun++;
    assert (obs === expv) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic preload(input logic [31:0] byteAddr, input logic [31:0] val);
    mem[byteAddr >> 2]    = val;
    refMem[byteAddr >> 2] = val;
  endtask

  // Called at a falling edge in IDLE; returns at the falling edge of cycle 1.
  task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d, input int n);
    src   = s;
    dst   = d;
    count = CNT_W'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full copy with per-cycle checks; word k is read in cycles 3k+1..3k+2 and written in 3k+3.
  task automatic runCopy(input string name, input logic [31:0] s, input logic [31:0] d,
                         input int n, input bit startBusy, input bit startFin);
    int total;
    int k;
    int ph;
    int donesBefore;
    logic [31:0] expAddr;
    logic [31:0] expDin;
    donesBefore = doneCount;
    total = 3 * n + 1;
    applyStimulus(s, d, n);
    for (int c = 1; c <= total + 2; c++) begin
      k  = (c - 1) / 3;
      ph = (c - 1) % 3;
      if (c <= 3 * n) begin
        expAddr = (ph == 2) ? d + 32'(4 * k) : s + 32'(4 * k);
        expDin  = 32'h0;
        if (ph == 2) begin
          expDin = refRead(s + 32'(4 * k));
          refMem[(d + 32'(4 * k)) >> 2] = expDin;
        end
        checkOutput($sformatf("%s c%0d busy", name, c), 32'(busy), 32'd1);
        checkOutput($sformatf("%s c%0d done", name, c), 32'(done), 32'd0);
        checkOutput($sformatf("%s c%0d m_de", name, c), 32'(m_de), 32'd1);
        checkOutput($sformatf("%s c%0d m_drw", name, c), 32'(m_drw), (ph == 2) ? 32'd1 : 32'd0);
        checkOutput($sformatf("%s c%0d m_daddr", name, c), m_daddr, expAddr);
        checkOutput($sformatf("%s c%0d m_din", name, c), m_din, expDin);
        checkOutput($sformatf("%s c%0d remaining", name, c), 32'(remaining), 32'(n - k));
      end else if (c == total) begin
        checkOutput($sformatf("%s c%0d done", name, c), 32'(done), 32'd1);
        checkOutput($sformatf("%s c%0d err", name, c), 32'(err), 32'd0);
        checkOutput($sformatf("%s c%0d busy", name, c), 32'(busy), 32'd0);
        checkOutput($sformatf("%s c%0d m_de", name, c), 32'(m_de), 32'd0);
        checkOutput($sformatf("%s c%0d remaining", name, c), 32'(remaining), 32'd0);
      end else begin
        checkOutput($sformatf("%s c%0d idle busy", name, c), 32'(busy), 32'd0);
        checkOutput($sformatf("%s c%0d idle done", name, c), 32'(done), 32'd0);
        checkOutput($sformatf("%s c%0d idle m_de", name, c), 32'(m_de), 32'd0);
      end
      start = (startBusy && c == 2) || (startFin && c == total);
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i <= n; i++) begin
      checkOutput($sformatf("%s word %0d", name, i), memRead(d + 32'(4 * i)), refRead(d + 32'(4 * i)));
    end
    checkOutput($sformatf("%s done pulses", name), 32'(doneCount - donesBefore), 32'd1);
  endtask

  // Requests that finish in cycle 1 without touching the RAM.
  task automatic runNoAccess(input string name, input logic [31:0] s, input logic [31:0] d,
                             input int n, input bit expErr);
    int deBefore;
    deBefore = deCount;
    applyStimulus(s, d, n);
    checkOutput({name, " done"}, 32'(done), 32'd1);
    checkOutput({name, " err"}, 32'(err), 32'(expErr));
    checkOutput({name, " busy"}, 32'(busy), 32'd0);
    checkOutput({name, " m_de"}, 32'(m_de), 32'd0);
    @(negedge clk);
    checkOutput({name, " done falls"}, 32'(done), 32'd0);
    checkOutput({name, " err falls"}, 32'(err), 32'd0);
    checkOutput({name, " busy idle"}, 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput({name, " no access"}, 32'(deCount - deBefore), 32'd0);
  endtask

  initial begin
    int n;
    int donesBefore;
    int wrBefore;
    logic [31:0] s;
    logic [31:0] d;

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    src   = 32'h0;
    dst   = 32'h0;
    count = '0;
    #1;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset m_daddr", m_daddr, 32'd0);
    checkOutput("reset remaining", 32'(remaining), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic copy");
    for (int i = 0; i < 4; i++) preload(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
    runCopy("basic", 32'h100, 32'h200, 4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("basic literal %0d", i), memRead(32'h200 + 32'(4 * i)), 32'hA0 + 32'(i));

    $display("[TB] zero count and misaligned requests");
    runNoAccess("zero", 32'h100, 32'h200, 0, 1'b0);
    runNoAccess("missrc", 32'h102, 32'h200, 4, 1'b1);
    runNoAccess("misdst", 32'h100, 32'h201, 4, 1'b1);

    $display("[TB] abort during second write");
    for (int i = 0; i < 8; i++) preload(32'h3000 + 32'(4 * i), $urandom);
    preload(32'h3408, 32'hDEAD_BEEF);
    donesBefore = doneCount;
    applyStimulus(32'h3000, 32'h3400, 8);
    repeat (5) @(negedge clk);
    checkOutput("abort in WR", 32'(m_drw), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort m_de", 32'(m_de), 32'd0);
    checkOutput("abort remaining", 32'(remaining), 32'd6);
    repeat (4) @(negedge clk);
    checkOutput("abort no done", 32'(doneCount - donesBefore), 32'd0);
    checkOutput("abort remaining held", 32'(remaining), 32'd6);
    for (int i = 0; i < 2; i++) refMem[(32'h3400 + 32'(4 * i)) >> 2] = refRead(32'h3000 + 32'(4 * i));
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("abort word %0d", i), memRead(32'h3400 + 32'(4 * i)), refRead(32'h3400 + 32'(4 * i)));

    $display("[TB] overlap and wrap");
    preload(32'h0, 32'd1);
    preload(32'h4, 32'd2);
    preload(32'h8, 32'd3);
    preload(32'hC, 32'd9);
    runCopy("overlap", 32'h0, 32'h4, 3, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++)
      checkOutput($sformatf("overlap literal %0d", i), memRead(32'(4 * i)), 32'd1);
    preload(32'hFFFF_FFFC, 32'h1234_5678);
    runCopy("wrap", 32'hFFFF_FFFC, 32'h800, 2, 1'b0, 1'b0);

    $display("[TB] reset mid-copy");
    preload(32'h100, 32'h5555_AAAA);
    preload(32'h600, 32'h0BAD_F00D);
    wrBefore = wrCount;
    applyStimulus(32'h100, 32'h600, 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset busy", 32'(busy), 32'd0);
    checkOutput("midreset done", 32'(done), 32'd0);
    checkOutput("midreset err", 32'(err), 32'd0);
    checkOutput("midreset m_de", 32'(m_de), 32'd0);
    checkOutput("midreset m_drw", 32'(m_drw), 32'd0);
    checkOutput("midreset m_daddr", m_daddr, 32'd0);
    checkOutput("midreset m_din", m_din, 32'd0);
    checkOutput("midreset remaining", 32'(remaining), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midreset no write", 32'(wrCount - wrBefore), 32'd0);
    checkOutput("midreset dst kept", memRead(32'h600), 32'h0BAD_F00D);

    $display("[TB] start filtering");
    runCopy("filter", 32'h100, 32'h900, 2, 1'b1, 1'b1);

    $display("[TB] randomized copies");
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 5);
      s = 32'h1000 + 32'(4 * $urandom_range(0, 15));
      d = 32'h2000 + 32'(4 * $urandom_range(0, 15));
      for (int i = 0; i < n; i++) preload(s + 32'(4 * i), $urandom);
      runCopy($sformatf("rand%0d", t), s, d, n, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
